// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: in-order queue of predicted branches. The oldest entry is
// resolved against the actual outcome. Each resolve produces a predictor update pulse.
// A mispredict also produces a flush with the corrected fetch PC.
module branch_resolution_unit #(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_valid,
    input  logic [PC_W-1:0]              push_pc,
    input  logic                         push_pred,
    input  logic [PC_W-1:0]              push_target,
    output logic                         push_ready,
    input  logic                         resolve_valid,
    input  logic                         resolve_taken,
    input  logic [PC_W-1:0]              resolve_target,
    output logic                         upd_branch,
    output logic [PC_W-1:0]              upd_pc,
    output logic                         upd_taken,
    output logic                         flush,
    output logic [PC_W-1:0]              redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]             mispred_cnt,
    output logic                         err_underflow
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] L_FULL    = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] L_CNT_MAX = {CNT_W{1'b1}};

    // Queue storage: predicted branch payload per slot
    logic [PC_W-1:0]  r_q_pc     [DEPTH];
    logic             r_q_pred   [DEPTH];
    logic [PC_W-1:0]  r_q_target [DEPTH];

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    logic             r_upd_branch;
    logic [PC_W-1:0]  r_upd_pc;
    logic             r_upd_taken;
    logic             r_flush;
    logic [PC_W-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_mispred_cnt;
    logic             r_err_underflow;

    logic             w_push_ready;
    logic             w_push_fire;
    logic             w_res_fire;
    logic             w_res_empty;
    logic [PC_W-1:0]  w_head_pc;
    logic             w_head_pred;
    logic [PC_W-1:0]  w_head_target;
    logic             w_mispred;
    logic             w_mispred_fire;
    logic [PC_W-1:0]  w_redirect;

    // Handshake and resolve qualification; no push into a flush cycle or a full queue
    always_comb begin
        w_push_ready   = (r_occ < L_FULL) & ~r_flush;
        w_push_fire    = push_valid & w_push_ready;
        w_res_fire     = resolve_valid & (r_occ != '0);
        w_res_empty    = resolve_valid & (r_occ == '0);
        w_head_pc      = r_q_pc[r_rd_ptr];
        w_head_pred    = r_q_pred[r_rd_ptr];
        w_head_target  = r_q_target[r_rd_ptr];
        w_mispred      = (resolve_taken != w_head_pred) |
                         (resolve_taken & w_head_pred & (resolve_target != w_head_target));
        w_mispred_fire = w_res_fire & w_mispred;
        w_redirect     = resolve_taken ? resolve_target : PC_W'(w_head_pc + PC_W'(1));
    end

    // Payload write; a push alongside a mispredict is wrong-path and dropped
    always_ff @(posedge clk) begin
        if (w_push_fire && !w_mispred_fire) begin
            r_q_pc[r_wr_ptr]     <= push_pc;
            r_q_pred[r_wr_ptr]   <= push_pred;
            r_q_target[r_wr_ptr] <= push_target;
        end
    end

    // Pointers and occupancy; mispredict empties the whole queue
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (w_mispred_fire) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push_fire) begin
                r_wr_ptr <= AW'(r_wr_ptr + AW'(1));
            end
            if (w_res_fire) begin
                r_rd_ptr <= AW'(r_rd_ptr + AW'(1));
            end
            case ({w_push_fire, w_res_fire})
                2'b10:   r_occ <= OCC_W'(r_occ + OCC_W'(1));
                2'b01:   r_occ <= OCC_W'(r_occ - OCC_W'(1));
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Predictor update pulse, one cycle after each resolve
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_upd_branch <= 1'b0;
            r_upd_pc     <= '0;
            r_upd_taken  <= 1'b0;
        end else begin
            r_upd_branch <= w_res_fire;
            if (w_res_fire) begin
                r_upd_pc    <= w_head_pc;
                r_upd_taken <= resolve_taken;
            end
        end
    end

    // Flush pulse, redirect target and saturating mispredict statistic
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_flush <= w_mispred_fire;
            if (w_mispred_fire) begin
                r_redirect_pc <= w_redirect;
                if (r_mispred_cnt != L_CNT_MAX) begin
                    r_mispred_cnt <= CNT_W'(r_mispred_cnt + CNT_W'(1));
                end
            end
        end
    end

    // Sticky underflow flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_underflow <= 1'b0;
        end else if (w_res_empty) begin
            r_err_underflow <= 1'b1;
        end
    end

    assign push_ready    = w_push_ready;
    assign upd_branch    = r_upd_branch;
    assign upd_pc        = r_upd_pc;
    assign upd_taken     = r_upd_taken;
    assign flush         = r_flush;
    assign redirect_pc   = r_redirect_pc;
    assign occupancy     = r_occ;
    assign mispred_cnt   = r_mispred_cnt;
    assign err_underflow = r_err_underflow;

endmodule
